// File: rtl/riscv_decode_stage_if.sv
// riscv_decode_stage_if
//   Groups the upstream instruction handshake, the flush request and the
//   downstream decoded-bundle handshake of the decode stage.
//   master : instruction source / bundle consumer (drives *_in signals)
//   slave  : the decode stage itself (drives *_out signals)
//   Upstream   : inst_valid_in, inst_ready_out, inst_in, pc_in, flush_in
//   Downstream : dec_valid_out, dec_ready_in, rd/rs1/rs2_out, imm_out, op_out,
//                rd_we_out, rs1_used_out, rs2_used_out, illegal_out, pc_out
interface riscv_decode_stage_if #(
  parameter int PC_WIDTH = 32
);
  logic                flush_in;
  logic                inst_valid_in;
  logic                inst_ready_out;
  logic [31:0]         inst_in;
  logic [PC_WIDTH-1:0] pc_in;
  logic                dec_valid_out;
  logic                dec_ready_in;
  logic [4:0]          rd_out;
  logic [4:0]          rs1_out;
  logic [4:0]          rs2_out;
  logic [31:0]         imm_out;
  logic [6:0]          op_out;
  logic                rd_we_out;
  logic                rs1_used_out;
  logic                rs2_used_out;
  logic                illegal_out;
  logic [PC_WIDTH-1:0] pc_out;

  modport master (
    output flush_in, inst_valid_in, inst_in, pc_in, dec_ready_in,
    input  inst_ready_out, dec_valid_out, rd_out, rs1_out, rs2_out, imm_out,
           op_out, rd_we_out, rs1_used_out, rs2_used_out, illegal_out, pc_out
  );

  modport slave (
    input  flush_in, inst_valid_in, inst_in, pc_in, dec_ready_in,
    output inst_ready_out, dec_valid_out, rd_out, rs1_out, rs2_out, imm_out,
           op_out, rd_we_out, rs1_used_out, rs2_used_out, illegal_out, pc_out
  );
endinterface

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage
//   Single-slot registered RV32I(+M) decode stage with valid/ready handshake.
//   An instruction accepted on one edge appears decoded on the outputs after
//   that edge; the slot holds while downstream stalls and can be refilled in
//   the same edge it is consumed. flush_in empties the slot and drops the
//   instruction offered in that cycle.
//   Ports:
//     clk_in   : clock, rising edge
//     rst_n_in : asynchronous active-low reset
//     bus      : riscv_decode_stage_if.slave (handshakes, instruction, bundle)

`ifndef RISCV_DEFS_SV
`define RISCV_DEFS_SV
`define LUI     7'd1
`define AUIPC   7'd2
`define JAL     7'd3
`define JALR    7'd4
`define BEQ     7'd5
`define BNE     7'd6
`define BLT     7'd7
`define BGE     7'd8
`define BLTU    7'd9
`define BGEU    7'd10
`define LB      7'd11
`define LH      7'd12
`define LW      7'd13
`define LBU     7'd14
`define LHU     7'd15
`define SB      7'd16
`define SH      7'd17
`define SW      7'd18
`define ADDI    7'd19
`define SLTI    7'd20
`define SLTIU   7'd21
`define XORI    7'd22
`define ORI     7'd23
`define ANDI    7'd24
`define SLLI    7'd25
`define SRLI    7'd26
`define SRAI    7'd27
`define ADD     7'd28
`define SUB     7'd29
`define SLL     7'd30
`define SLT     7'd31
`define SLTU    7'd32
`define XOR     7'd33
`define SRL     7'd34
`define SRA     7'd35
`define OR      7'd36
`define AND     7'd37
`define MUL     7'd38
`define MULH    7'd39
`define MULHSU  7'd40
`define MULHU   7'd41
`define DIV     7'd42
`define DIVU    7'd43
`define REM     7'd44
`define REMU    7'd45
`define FENCE   7'd46
`define ECALL   7'd47
`define EBREAK  7'd48
`define ILLEGAL 7'd127
`endif

module riscv_decode_stage #(
  parameter int ENABLE_M      = 1,
  parameter int ENABLE_SYSTEM = 1,
  parameter int PC_WIDTH      = 32
) (
  input logic                 clk_in,
  input logic                 rst_n_in,
  riscv_decode_stage_if.slave bus
);

  logic [31:0] inst_p0;
  logic [6:0]  opc_p0;
  logic [2:0]  f3_p0;
  logic [6:0]  f7_p0;

  logic               legal_p0;
  logic [6:0]         op_p0;
  logic signed [31:0] imm_p0;
  logic               has_rd_p0;
  logic               use1_p0;
  logic               use2_p0;

  logic signed [31:0] imm_i_p0, imm_s_p0, imm_b_p0, imm_u_p0, imm_j_p0;

  logic accept_p0;

  logic                vld_p1;
  logic [6:0]          op_p1;
  logic [31:0]         imm_p1;
  logic [4:0]          rd_p1, rs1_p1, rs2_p1;
  logic                rd_we_p1, use1_p1, use2_p1, illegal_p1;
  logic [PC_WIDTH-1:0] pc_p1;

  // ---- stage 0: combinational decode of the offered instruction ----
  assign inst_p0 = bus.inst_in;
  assign opc_p0  = inst_p0[6:0];
  assign f3_p0   = inst_p0[14:12];
  assign f7_p0   = inst_p0[31:25];

  assign imm_i_p0 = {{20{inst_p0[31]}}, inst_p0[31:20]};
  assign imm_s_p0 = {{20{inst_p0[31]}}, inst_p0[31:25], inst_p0[11:7]};
  assign imm_b_p0 = {{19{inst_p0[31]}}, inst_p0[31], inst_p0[7],
                     inst_p0[30:25], inst_p0[11:8], 1'b0};
  assign imm_u_p0 = {inst_p0[31:12], 12'b0};
  assign imm_j_p0 = {{11{inst_p0[31]}}, inst_p0[31], inst_p0[19:12],
                     inst_p0[20], inst_p0[30:21], 1'b0};

  // Format flags and immediate are set per opcode; legal/op only where the
  // full funct3/funct7 combination is mapped, so anything unmatched falls
  // through as illegal and gets its fields masked below.
  always_comb begin
    legal_p0  = 1'b0;
    op_p0     = `ILLEGAL;
    imm_p0    = '0;
    has_rd_p0 = 1'b0;
    use1_p0   = 1'b0;
    use2_p0   = 1'b0;
    case (opc_p0)
      7'h37: begin
        legal_p0 = 1'b1; op_p0 = `LUI; imm_p0 = imm_u_p0; has_rd_p0 = 1'b1;
      end
      7'h17: begin
        legal_p0 = 1'b1; op_p0 = `AUIPC; imm_p0 = imm_u_p0; has_rd_p0 = 1'b1;
      end
      7'h6F: begin
        legal_p0 = 1'b1; op_p0 = `JAL; imm_p0 = imm_j_p0; has_rd_p0 = 1'b1;
      end
      7'h67: begin
        imm_p0 = imm_i_p0; has_rd_p0 = 1'b1; use1_p0 = 1'b1;
        if (f3_p0 == 3'd0) begin legal_p0 = 1'b1; op_p0 = `JALR; end
      end
      7'h63: begin
        imm_p0 = imm_b_p0; use1_p0 = 1'b1; use2_p0 = 1'b1;
        case (f3_p0)
          3'd0: begin legal_p0 = 1'b1; op_p0 = `BEQ;  end
          3'd1: begin legal_p0 = 1'b1; op_p0 = `BNE;  end
          3'd4: begin legal_p0 = 1'b1; op_p0 = `BLT;  end
          3'd5: begin legal_p0 = 1'b1; op_p0 = `BGE;  end
          3'd6: begin legal_p0 = 1'b1; op_p0 = `BLTU; end
          3'd7: begin legal_p0 = 1'b1; op_p0 = `BGEU; end
          default: ;
        endcase
      end
      7'h03: begin
        imm_p0 = imm_i_p0; has_rd_p0 = 1'b1; use1_p0 = 1'b1;
        case (f3_p0)
          3'd0: begin legal_p0 = 1'b1; op_p0 = `LB;  end
          3'd1: begin legal_p0 = 1'b1; op_p0 = `LH;  end
          3'd2: begin legal_p0 = 1'b1; op_p0 = `LW;  end
          3'd4: begin legal_p0 = 1'b1; op_p0 = `LBU; end
          3'd5: begin legal_p0 = 1'b1; op_p0 = `LHU; end
          default: ;
        endcase
      end
      7'h23: begin
        imm_p0 = imm_s_p0; use1_p0 = 1'b1; use2_p0 = 1'b1;
        case (f3_p0)
          3'd0: begin legal_p0 = 1'b1; op_p0 = `SB; end
          3'd1: begin legal_p0 = 1'b1; op_p0 = `SH; end
          3'd2: begin legal_p0 = 1'b1; op_p0 = `SW; end
          default: ;
        endcase
      end
      7'h13: begin
        imm_p0 = imm_i_p0; has_rd_p0 = 1'b1; use1_p0 = 1'b1;
        case (f3_p0)
          3'd0: begin legal_p0 = 1'b1; op_p0 = `ADDI;  end
          3'd2: begin legal_p0 = 1'b1; op_p0 = `SLTI;  end
          3'd3: begin legal_p0 = 1'b1; op_p0 = `SLTIU; end
          3'd4: begin legal_p0 = 1'b1; op_p0 = `XORI;  end
          3'd6: begin legal_p0 = 1'b1; op_p0 = `ORI;   end
          3'd7: begin legal_p0 = 1'b1; op_p0 = `ANDI;  end
          3'd1: if (f7_p0 == 7'h00) begin legal_p0 = 1'b1; op_p0 = `SLLI; end
          3'd5: begin
            if (f7_p0 == 7'h00) begin legal_p0 = 1'b1; op_p0 = `SRLI; end
            else if (f7_p0 == 7'h20) begin legal_p0 = 1'b1; op_p0 = `SRAI; end
          end
          default: ;
        endcase
      end
      7'h33: begin
        has_rd_p0 = 1'b1; use1_p0 = 1'b1; use2_p0 = 1'b1;
        if (f7_p0 == 7'h00) begin
          legal_p0 = 1'b1;
          case (f3_p0)
            3'd0: op_p0 = `ADD;
            3'd1: op_p0 = `SLL;
            3'd2: op_p0 = `SLT;
            3'd3: op_p0 = `SLTU;
            3'd4: op_p0 = `XOR;
            3'd5: op_p0 = `SRL;
            3'd6: op_p0 = `OR;
            default: op_p0 = `AND;
          endcase
        end else if (f7_p0 == 7'h20) begin
          if (f3_p0 == 3'd0) begin legal_p0 = 1'b1; op_p0 = `SUB; end
          else if (f3_p0 == 3'd5) begin legal_p0 = 1'b1; op_p0 = `SRA; end
        end else if (f7_p0 == 7'h01 && ENABLE_M != 0) begin
          legal_p0 = 1'b1;
          case (f3_p0)
            3'd0: op_p0 = `MUL;
            3'd1: op_p0 = `MULH;
            3'd2: op_p0 = `MULHSU;
            3'd3: op_p0 = `MULHU;
            3'd4: op_p0 = `DIV;
            3'd5: op_p0 = `DIVU;
            3'd6: op_p0 = `REM;
            default: op_p0 = `REMU;
          endcase
        end
      end
      7'h0F: begin
        // FENCE carries pred/succ in its I-immediate; rd/rs1 are reserved.
        imm_p0 = imm_i_p0;
        if (ENABLE_SYSTEM != 0 && f3_p0 == 3'd0) begin
          legal_p0 = 1'b1; op_p0 = `FENCE;
        end
      end
      7'h73: begin
        if (ENABLE_SYSTEM != 0 && f3_p0 == 3'd0) begin
          if (inst_p0[31:20] == 12'd0) begin legal_p0 = 1'b1; op_p0 = `ECALL; end
          else if (inst_p0[31:20] == 12'd1) begin legal_p0 = 1'b1; op_p0 = `EBREAK; end
        end
      end
      default: ;
    endcase
  end

  assign bus.inst_ready_out = !vld_p1 || bus.dec_ready_in;
  assign accept_p0 = bus.inst_valid_in && bus.inst_ready_out && !bus.flush_in;

  // ---- stage 1: registered bundle slot ----
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p1     <= 1'b0;
      op_p1      <= '0;
      imm_p1     <= '0;
      rd_p1      <= '0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_we_p1   <= 1'b0;
      use1_p1    <= 1'b0;
      use2_p1    <= 1'b0;
      illegal_p1 <= 1'b0;
      pc_p1      <= '0;
    end else begin
      if (bus.flush_in)          vld_p1 <= 1'b0;
      else if (accept_p0)        vld_p1 <= 1'b1;
      else if (bus.dec_ready_in) vld_p1 <= 1'b0;

      if (accept_p0) begin
        op_p1      <= op_p0;
        imm_p1     <= legal_p0 ? imm_p0 : 32'd0;
        rd_p1      <= (legal_p0 && has_rd_p0) ? inst_p0[11:7]  : 5'd0;
        rs1_p1     <= (legal_p0 && use1_p0)   ? inst_p0[19:15] : 5'd0;
        rs2_p1     <= (legal_p0 && use2_p0)   ? inst_p0[24:20] : 5'd0;
        rd_we_p1   <= legal_p0 && has_rd_p0 && (inst_p0[11:7] != 5'd0);
        use1_p1    <= legal_p0 && use1_p0;
        use2_p1    <= legal_p0 && use2_p0;
        illegal_p1 <= !legal_p0;
        pc_p1      <= bus.pc_in;
      end
    end
  end

  assign bus.dec_valid_out = vld_p1;
  assign bus.op_out        = op_p1;
  assign bus.imm_out       = imm_p1;
  assign bus.rd_out        = rd_p1;
  assign bus.rs1_out       = rs1_p1;
  assign bus.rs2_out       = rs2_p1;
  assign bus.rd_we_out     = rd_we_p1;
  assign bus.rs1_used_out  = use1_p1;
  assign bus.rs2_used_out  = use2_p1;
  assign bus.illegal_out   = illegal_p1;
  assign bus.pc_out        = pc_p1;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb_riscv_decode_stage
//   Directed bench for riscv_decode_stage: a default instance (M and SYSTEM
//   enabled) and a second instance with both extensions disabled.
module tb_riscv_decode_stage;

  localparam logic [6:0] OP_LUI = 7'd1, OP_JAL = 7'd3, OP_BEQ = 7'd5,
                         OP_SW = 7'd18, OP_ADDI = 7'd19, OP_SUB = 7'd29,
                         OP_MUL = 7'd38, OP_ECALL = 7'd47, OP_ILLEGAL = 7'd127;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  riscv_decode_stage_if #(.PC_WIDTH(32)) ifc ();
  riscv_decode_stage_if #(.PC_WIDTH(32)) ifm ();

  riscv_decode_stage dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (ifc)
  );

  riscv_decode_stage #(.ENABLE_M(0), .ENABLE_SYSTEM(0), .PC_WIDTH(32)) dut_nm (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (ifm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, rd, 7'h13};
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    ifc.inst_in       = inst;
    ifc.pc_in         = pc;
    ifc.inst_valid_in = 1'b1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ifc.flush_in = 1'b0; ifc.inst_valid_in = 1'b0; ifc.inst_in = '0;
    ifc.pc_in = '0; ifc.dec_ready_in = 1'b1;
    ifm.flush_in = 1'b0; ifm.inst_valid_in = 1'b0; ifm.inst_in = '0;
    ifm.pc_in = '0; ifm.dec_ready_in = 1'b1;

    #12;
    chk("rst_valid",   32'(ifc.dec_valid_out), 32'd0);
    chk("rst_ready",   32'(ifc.inst_ready_out), 32'd1);
    chk("rst_imm",     ifc.imm_out, 32'd0);
    chk("rst_op",      32'(ifc.op_out), 32'd0);
    chk("rst_pc",      ifc.pc_out, 32'd0);
    chk("rst_illegal", 32'(ifc.illegal_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x0,5
    drive(32'h00500093, 32'h100);
    edge_wait();
    ifc.inst_valid_in = 1'b0;
    chk("addi_valid", 32'(ifc.dec_valid_out), 32'd1);
    chk("addi_op",    32'(ifc.op_out), 32'(OP_ADDI));
    chk("addi_rd",    32'(ifc.rd_out), 32'd1);
    chk("addi_rs1",   32'(ifc.rs1_out), 32'd0);
    chk("addi_imm",   ifc.imm_out, 32'h00000005);
    chk("addi_rdwe",  32'(ifc.rd_we_out), 32'd1);
    chk("addi_pc",    ifc.pc_out, 32'h100);
    chk("addi_u1",    32'(ifc.rs1_used_out), 32'd1);
    chk("addi_u2",    32'(ifc.rs2_used_out), 32'd0);

    edge_wait();
    chk("drain_valid", 32'(ifc.dec_valid_out), 32'd0);

    // beq x1,x2,-4
    drive(32'hFE208EE3, 32'h104);
    edge_wait();
    chk("beq_op",   32'(ifc.op_out), 32'(OP_BEQ));
    chk("beq_rs1",  32'(ifc.rs1_out), 32'd1);
    chk("beq_rs2",  32'(ifc.rs2_out), 32'd2);
    chk("beq_imm",  ifc.imm_out, 32'hFFFFFFFC);
    chk("beq_rdwe", 32'(ifc.rd_we_out), 32'd0);
    chk("beq_rd",   32'(ifc.rd_out), 32'd0);

    // jal x1,+8 (back-to-back, consumed and replaced in one edge)
    drive(32'h008000EF, 32'h108);
    edge_wait();
    chk("jal_valid", 32'(ifc.dec_valid_out), 32'd1);
    chk("jal_op",    32'(ifc.op_out), 32'(OP_JAL));
    chk("jal_rd",    32'(ifc.rd_out), 32'd1);
    chk("jal_imm",   ifc.imm_out, 32'h00000008);
    chk("jal_pc",    ifc.pc_out, 32'h108);

    // lui x5,0x12345
    drive(32'h123452B7, 32'h10C);
    edge_wait();
    chk("lui_op",  32'(ifc.op_out), 32'(OP_LUI));
    chk("lui_rd",  32'(ifc.rd_out), 32'd5);
    chk("lui_imm", ifc.imm_out, 32'h12345000);
    chk("lui_u1",  32'(ifc.rs1_used_out), 32'd0);

    // sw x2,8(x1)
    drive(32'h0020A423, 32'h110);
    edge_wait();
    chk("sw_op",   32'(ifc.op_out), 32'(OP_SW));
    chk("sw_imm",  ifc.imm_out, 32'h00000008);
    chk("sw_rdwe", 32'(ifc.rd_we_out), 32'd0);
    chk("sw_u2",   32'(ifc.rs2_used_out), 32'd1);

    // sub x5,x1,x2
    drive(32'h402082B3, 32'h114);
    edge_wait();
    chk("sub_op",  32'(ifc.op_out), 32'(OP_SUB));
    chk("sub_rd",  32'(ifc.rd_out), 32'd5);
    chk("sub_imm", ifc.imm_out, 32'd0);

    // mul x3,x1,x2 on both instances
    drive(32'h022081B3, 32'h118);
    ifm.inst_in = 32'h022081B3; ifm.pc_in = 32'h118; ifm.inst_valid_in = 1'b1;
    edge_wait();
    ifm.inst_valid_in = 1'b0;
    chk("mul_op",     32'(ifc.op_out), 32'(OP_MUL));
    chk("mul_rd",     32'(ifc.rd_out), 32'd3);
    chk("mul_ill",    32'(ifc.illegal_out), 32'd0);
    chk("nm_mul_ill", 32'(ifm.illegal_out), 32'd1);
    chk("nm_mul_op",  32'(ifm.op_out), 32'(OP_ILLEGAL));
    chk("nm_mul_we",  32'(ifm.rd_we_out), 32'd0);
    chk("nm_mul_u1",  32'(ifm.rs1_used_out), 32'd0);

    // ecall on both instances
    drive(32'h00000073, 32'h11C);
    ifm.inst_in = 32'h00000073; ifm.inst_valid_in = 1'b1;
    edge_wait();
    ifm.inst_valid_in = 1'b0;
    chk("ecall_op",   32'(ifc.op_out), 32'(OP_ECALL));
    chk("ecall_imm",  ifc.imm_out, 32'd0);
    chk("ecall_we",   32'(ifc.rd_we_out), 32'd0);
    chk("nm_ecall_ill", 32'(ifm.illegal_out), 32'd1);

    // slli with funct7=0x20 is not a valid shift
    drive(32'h40001093, 32'h120);
    edge_wait();
    chk("slli_ill", 32'(ifc.illegal_out), 32'd1);
    chk("slli_op",  32'(ifc.op_out), 32'(OP_ILLEGAL));
    chk("slli_we",  32'(ifc.rd_we_out), 32'd0);

    // addi encoding with inst[1:0]=00
    drive(32'h00500090, 32'h124);
    edge_wait();
    chk("lowbits_ill", 32'(ifc.illegal_out), 32'd1);
    chk("lowbits_we",  32'(ifc.rd_we_out), 32'd0);

    // jalr with funct3=1
    drive(32'h000010E7, 32'h128);
    edge_wait();
    ifc.inst_valid_in = 1'b0;
    chk("jalr_ill", 32'(ifc.illegal_out), 32'd1);
    chk("jalr_op",  32'(ifc.op_out), 32'(OP_ILLEGAL));
    edge_wait();

    // stall for three edges with B waiting upstream
    ifc.dec_ready_in = 1'b0;
    drive(addi(5'd1, 12'd1), 32'h200);
    edge_wait();
    drive(addi(5'd2, 12'd2), 32'h204);
    #1;
    chk("stall_ready0", 32'(ifc.inst_ready_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      chk("stall_valid", 32'(ifc.dec_valid_out), 32'd1);
      chk("stall_rd",    32'(ifc.rd_out), 32'd1);
      chk("stall_imm",   ifc.imm_out, 32'd1);
      chk("stall_pc",    ifc.pc_out, 32'h200);
      chk("stall_ready", 32'(ifc.inst_ready_out), 32'd0);
    end
    ifc.dec_ready_in = 1'b1;
    #1;
    chk("release_ready", 32'(ifc.inst_ready_out), 32'd1);
    edge_wait();
    chk("b_rd", 32'(ifc.rd_out), 32'd2);
    chk("b_pc", ifc.pc_out, 32'h204);
    drive(addi(5'd3, 12'd3), 32'h208);
    edge_wait();
    chk("c_rd", 32'(ifc.rd_out), 32'd3);
    chk("c_pc", ifc.pc_out, 32'h208);
    drive(addi(5'd4, 12'd4), 32'h20C);
    edge_wait();
    ifc.inst_valid_in = 1'b0;
    chk("d_rd",    32'(ifc.rd_out), 32'd4);
    chk("d_valid", 32'(ifc.dec_valid_out), 32'd1);
    edge_wait();
    chk("stream_end", 32'(ifc.dec_valid_out), 32'd0);

    // flush with a held bundle and a valid input offered
    ifc.dec_ready_in = 1'b0;
    drive(addi(5'd6, 12'd6), 32'h300);
    edge_wait();
    chk("flush_held", 32'(ifc.dec_valid_out), 32'd1);
    drive(addi(5'd7, 12'd7), 32'h304);
    ifc.flush_in = 1'b1;
    edge_wait();
    ifc.flush_in = 1'b0;
    ifc.inst_valid_in = 1'b0;
    chk("flush_valid", 32'(ifc.dec_valid_out), 32'd0);
    ifc.dec_ready_in = 1'b1;
    edge_wait();
    chk("flush_dropped", 32'(ifc.dec_valid_out), 32'd0);

    // asynchronous reset in the middle of a stall
    ifc.dec_ready_in = 1'b0;
    drive(addi(5'd8, 12'd8), 32'h400);
    edge_wait();
    ifc.inst_valid_in = 1'b0;
    chk("prerst_valid", 32'(ifc.dec_valid_out), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ifc.dec_valid_out), 32'd0);
    chk("arst_rd",    32'(ifc.rd_out), 32'd0);
    chk("arst_imm",   ifc.imm_out, 32'd0);
    chk("arst_pc",    ifc.pc_out, 32'd0);
    chk("arst_we",    32'(ifc.rd_we_out), 32'd0);
    chk("arst_ready", 32'(ifc.inst_ready_out), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ifc.dec_ready_in = 1'b1;
    edge_wait();
    chk("postrst_valid", 32'(ifc.dec_valid_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_decode_stage.md
RISCV_DECODE_STAGE -- requirements
Module: riscv_decode_stage

Interface
REQ-001 Parameter ENABLE_M, default 1, meaning: when 1, RV32M opcodes decode as legal; when 0, they are flagged illegal.
REQ-002 Parameter ENABLE_SYSTEM, default 1, meaning: when 1, ECALL, EBREAK and FENCE decode as legal; when 0, they are flagged illegal.
REQ-003 Parameter PC_WIDTH, default 32, meaning: width of the program-counter sideband carried alongside each instruction.
REQ-004 Port clk_in  input  1  system clock; the block uses one clock, all state is updated on its rising edge.
REQ-005 Port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 Port flush_in  input  1  discard the held instruction; drop any input offered this cycle.
REQ-007 Port inst_valid_in  input  1  upstream instruction is valid.
REQ-008 Port inst_ready_out  output  1  stage accepts an instruction this cycle.
REQ-009 Port inst_in  input  32  raw instruction word.
REQ-010 Port pc_in  input  PC_WIDTH  address of inst_in.
REQ-011 Port dec_valid_out  output  1  decoded bundle is valid.
REQ-012 Port dec_ready_in  input  1  downstream consumes the bundle this cycle.
REQ-013 Ports rd_out, rs1_out, rs2_out  output  5 each  register indices.
REQ-014 Port imm_out  output  32  sign-extended immediate.
REQ-015 Port op_out  output  7  operation code, using the riscv_defs.sv macros plus `ECALL, `EBREAK, `FENCE, `ILLEGAL.
REQ-016 Ports rd_we_out, rs1_used_out, rs2_used_out, illegal_out  output  1 each  decode flags.
REQ-017 Port pc_out  output  PC_WIDTH  registered pc_in.

Function
REQ-018 The stage is a single registered slot with a valid bit; all outputs are registered, except inst_ready_out, which equals !dec_valid_out || dec_ready_in.
REQ-019 Transfer in happens when inst_valid_in && inst_ready_out && !flush_in; the decoded bundle appears on the outputs 1 cycle later (latency 1, throughput 1 per cycle).
REQ-020 Bundle and valid hold stable while dec_valid_out && !dec_ready_in; no overwrite, no drop.
REQ-021 Simultaneous consume and accept: the new bundle replaces the old one in the same edge; valid stays 1.
REQ-022 flush_in=1: the valid bit clears next edge; this has priority over consume and accept; data registers may hold stale values.
REQ-023 Decode covers RV32I: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC-MEM, SYSTEM (funct3=0; imm12=0 is ECALL, imm12=1 is EBREAK); with ENABLE_M=1, it also covers OP with funct7=0x01.
REQ-024 Immediates: I = sext(inst[31:20]).
REQ-025 Immediates: S = sext({inst[31:25],inst[11:7]}).
REQ-026 Immediates: B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
REQ-027 Immediates: U = {inst[31:12],12'b0}.
REQ-028 Immediates: J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
REQ-029 Immediates: R-type and SYSTEM instructions produce imm_out=0.
REQ-030 Any unmapped opcode, funct3 or funct7 combination (including inst[1:0]!=2'b11, shift-immediate funct7 other than 0x00 or 0x20, JALR funct3!=0, and disabled extensions) sets illegal_out=1, op_out=`ILLEGAL, and rd_we_out, rs1_used_out and rs2_used_out to 0.
REQ-031 Every output is fully defined for every input; no latched or undriven fields; unused register fields are driven to 0.
REQ-032 rd_we_out=1 only for legal instructions with an rd field and rd!=0; STORE, BRANCH, FENCE, ECALL and EBREAK give 0.
REQ-033 rs1_used_out and rs2_used_out reflect the format: R uses both; I, LOAD and JALR use rs1; S and B use both; U, J and SYSTEM use neither.

Reset
REQ-034 rst_n_in low asserts immediately (asynchronously): dec_valid_out=0, all data outputs 0, illegal_out=0.
REQ-035 During reset, inst_ready_out=1; release is synchronous to the next clk_in edge after deassertion.
REQ-036 Reset during a stall discards the held bundle; no partial bundle is emitted after release.

Verification
REQ-037 Scenario: inst 0x00500093, pc 0x100, ready=1 -> next cycle valid=1, op=`ADDI, rd=1, rs1=0, imm=0x00000005, rd_we=1, pc_out=0x100.
REQ-038 Scenario: inst 0xFE208EE3 (beq x1,x2,-4) -> op=`BEQ, rs1=1, rs2=2, imm=0xFFFFFFFC, rd_we=0; and inst 0x008000EF -> op=`JAL, rd=1, imm=0x00000008.
REQ-039 Scenario: inst 0x123452B7 -> op=`LUI, rd=5, imm=0x12345000, rs1_used=0.
REQ-040 Scenario: inst 0x022081B3 with ENABLE_M=0 -> illegal_out=1, op=`ILLEGAL, rd_we=0; with ENABLE_M=1 -> op=`MUL, rd=3.
REQ-041 Scenario: dec_ready_in=0 for 3 cycles with a back-to-back input stream -> outputs stable, inst_ready_out=0, no instruction lost or duplicated after release.
REQ-042 Scenario: flush_in=1 coincident with a valid input and a held bundle -> dec_valid_out=0 next cycle; rst_n_in pulsed low mid-stall -> outputs 0 immediately.
